sdram_host_arbiter: RTL and testbench
=====================================

Name: sdram_host_arbiter

Overview:
- Sits between NUM_CH independent client ports and the single host side of sdram_controller (the wr/rd/busy host interface).
- Arbitrates requests round-robin, issues one command at a time to the controller, and routes read data back to the requesting channel.
- Adds a read-timeout watchdog and per-channel error reporting.
- Lets the buzzer/LED/display logic and future DMA engines share one SDRAM.

Parameters:
- NUM_CH, 4: number of client channels, 2..8.
- ADDR_W, 32: address width; matches the controller wr_addr/rd_addr.
- DATA_W, 16: data width; matches the controller wr_data/rd_data.
- TIMEOUT_CYC, 1024: clk cycles to wait for sd_rd_ready before aborting a read.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  packed per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  packed per-channel write data.
- rsp_valid  out  NUM_CH  one-cycle pulse: read data valid for that channel.
- rsp_err  out  NUM_CH  one-cycle pulse: read timed out for that channel.
- rsp_rdata  out  DATA_W  shared read data; qualified by rsp_valid.
- sd_wr_addr  out  ADDR_W  to controller wr_addr.
- sd_wr_data  out  DATA_W  to controller wr_data.
- sd_wr_enable  out  1  one-cycle write strobe.
- sd_rd_addr  out  ADDR_W  to controller rd_addr.
- sd_rd_enable  out  1  one-cycle read strobe.
- sd_rd_data  in  DATA_W  from controller rd_data.
- sd_rd_ready  in  1  from controller rd_ready; one-cycle pulse.
- sd_busy  in  1  from controller busy.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state IDLE; rr pointer = NUM_CH-1, so channel 0 wins first.
  - Timeout counter 0.
  - A read in flight is abandoned; a late sd_rd_ready after reset is ignored.
- Handshake: a request is accepted in the cycle where req_valid[i] && req_ready[i]. A client holds valid, we, addr and wdata stable until accepted.
- State machine (registered):
  - IDLE: req_ready = 0 while sd_busy = 1. When sd_busy = 0 and any valid, assert req_ready[g] combinationally, where g is the first valid channel searching from ptr+1 with wrap. Latch we/addr/wdata and g, set ptr = g, go ISSUE.
  - ISSUE: exactly one cycle. Drive sd_wr_enable or sd_rd_enable = 1 with the latched address/data. go GUARD.
  - GUARD: one cycle, ignoring sd_busy; this covers the controller's one-cycle busy latency. Write -> WAIT_BUSY. Read -> WAIT_RD.
  - WAIT_BUSY: when sd_busy = 0 -> IDLE.
  - WAIT_RD:
    - On sd_rd_ready, register sd_rd_data to rsp_rdata, pulse rsp_valid[g] next cycle, go WAIT_BUSY.
    - Otherwise, if the counter reaches TIMEOUT_CYC-1, pulse rsp_err[g], go WAIT_BUSY.
    - The counter clears on entry to WAIT_RD.
- Outstanding commands: at most one in flight; a new command is never issued while sd_busy = 1.
- sd_*_addr/data hold their last values between commands. They are driven from latched registers, never directly from the req_* inputs.
- sd_rd_ready outside WAIT_RD is ignored and produces no rsp pulse.
- Latency, idle bus, write: accept in cycle 0, sd_wr_enable in cycle 1, next accept no earlier than cycle 3 plus busy time.
- Latency, read: rsp_valid one cycle after sd_rd_ready.
- Fairness: a continuously requesting channel is served at most once per NUM_CH grants when all channels request.
- Simultaneous: a channel may drop req_valid before accept without penalty; ptr advances only on an actual grant.

Decomposition:
- Package sdram_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, GUARD, WAIT_BUSY, WAIT_RD}.
  - Function clog2-based CH_W for grant index width.
  - Timeout counter width localparam derived from TIMEOUT_CYC.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and index; combinational.
  - Reused by later bus muxes.

Test Plan:
- Single write: ch1 valid, we = 1, addr 0x100, wdata 0xBEEF, busy low -> req_ready[1] pulses once; sd_wr_enable high for exactly 1 cycle with addr 0x100, data 0xBEEF.
- Read routing: ch2 reads 0x20; the model returns 0x1234 with sd_rd_ready 5 cycles later -> rsp_valid[2] a single pulse, rsp_rdata = 0x1234, other rsp bits 0.
- Round-robin: all 4 channels hold valid writes -> grant order 0,1,2,3,0; no channel is granted twice within 4 grants.
- Busy backpressure: sd_busy held high for 20 cycles with ch0 valid -> req_ready stays 0 and no enable strobes; accept occurs in the first cycle busy = 0.
- Timeout: TIMEOUT_CYC = 16, ch3 read with no sd_rd_ready -> rsp_err[3] pulse 16 cycles after GUARD, no rsp_valid, arbiter returns to IDLE and serves ch0 next.
- Reset mid-read: rst_n low during WAIT_RD, then a late sd_rd_ready -> all outputs 0 immediately, no rsp_valid pulse, first grant after release goes to ch0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and width helpers for the SDRAM host arbiter and its round-robin picker.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT_BUSY,
    WAIT_RD
  } arb_state_t;

  // Grant index width; never narrower than one bit so a 1-channel build still elaborates.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Read-timeout counter width: it only has to reach TIMEOUT_CYC-1.
  function automatic int to_cnt_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping around.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = W'(c);
      end
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Shares the single sdram_controller host port among NUM_CH clients: round-robin grant,
// one command in flight, read-data routing and a read-timeout watchdog.
module sdram_host_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [NUM_CH-1:0]        rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        sd_wr_addr,
  output logic [DATA_W-1:0]        sd_wr_data,
  output logic                     sd_wr_enable,
  output logic [ADDR_W-1:0]        sd_rd_addr,
  output logic                     sd_rd_enable,
  input  logic [DATA_W-1:0]        sd_rd_data,
  input  logic                     sd_rd_ready,
  input  logic                     sd_busy
);

  localparam int              CH_W    = ch_w(NUM_CH);
  localparam int              TO_W    = to_cnt_w(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_t        state_reg;
  logic [CH_W-1:0]   ptr_reg;
  logic [NUM_CH-1:0] gnt_vec_reg;
  logic              we_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [NUM_CH-1:0] sel_grant;
  logic [CH_W-1:0]   sel_idx;
  logic              accept;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (sel_grant),
    .idx   (sel_idx)
  );

  // rst_n gates the combinational grant so every output reads 0 while reset is held.
  assign accept    = rst_n && (state_reg == IDLE) && !sd_busy && (req_valid != '0);
  assign req_ready = accept ? sel_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= CH_W'(NUM_CH - 1);
      gnt_vec_reg  <= '0;
      we_reg       <= 1'b0;
      to_cnt_reg   <= '0;
      rsp_valid    <= '0;
      rsp_err      <= '0;
      rsp_rdata    <= '0;
      sd_wr_addr   <= '0;
      sd_wr_data   <= '0;
      sd_wr_enable <= 1'b0;
      sd_rd_addr   <= '0;
      sd_rd_enable <= 1'b0;
    end else begin
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      rsp_valid    <= '0;
      rsp_err      <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ptr_reg     <= sel_idx;
            gnt_vec_reg <= sel_grant;
            we_reg      <= req_we[sel_idx];
            if (req_we[sel_idx]) begin
              sd_wr_addr   <= addr_arr[sel_idx];
              sd_wr_data   <= wdata_arr[sel_idx];
              sd_wr_enable <= 1'b1;
            end else begin
              sd_rd_addr   <= addr_arr[sel_idx];
              sd_rd_enable <= 1'b1;
            end
            state_reg <= ISSUE;
          end
        end
        ISSUE: state_reg <= GUARD;
        // The controller raises busy one cycle after the strobe, so this cycle ignores it.
        GUARD: begin
          to_cnt_reg <= '0;
          state_reg  <= we_reg ? WAIT_BUSY : WAIT_RD;
        end
        WAIT_RD: begin
          if (sd_rd_ready) begin
            rsp_rdata <= sd_rd_data;
            rsp_valid <= gnt_vec_reg;
            state_reg <= WAIT_BUSY;
          end else if (to_cnt_reg == TO_LAST) begin
            rsp_err   <= gnt_vec_reg;
            state_reg <= WAIT_BUSY;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        WAIT_BUSY: begin
          if (!sd_busy) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked every cycle against a
// transaction-timeline model of the arbiter.
module tb_sdram_host_arbiter;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH*DATA_W-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [NUM_CH-1:0]        rsp_err;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [ADDR_W-1:0]        sd_wr_addr;
  logic [DATA_W-1:0]        sd_wr_data;
  logic                     sd_wr_enable;
  logic [ADDR_W-1:0]        sd_rd_addr;
  logic                     sd_rd_enable;
  logic [DATA_W-1:0]        sd_rd_data = '0;
  logic                     sd_rd_ready = 1'b0;
  logic                     sd_busy = 1'b0;

  always #5 clk = ~clk;

  sdram_host_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- model: timeline of the single outstanding command ----------------
  int                cyc = 0;
  bit                m_free;
  int                m_ptr;
  int                wait_from;
  bit                rd_open;
  int                rd_from, rd_to;
  int                rsp_at;
  bit                rsp_is_err;
  int                rsp_ch;
  logic [DATA_W-1:0] rsp_dat;
  int                strobe_at;
  bit                strobe_we;
  int                cur_ch;
  logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
  logic [DATA_W-1:0] e_wr_data;
  int                n_txn = 0;

  function automatic void model_reset();
    m_free    = 1'b1;
    m_ptr     = NUM_CH - 1;
    wait_from = -1;
    rd_open   = 1'b0;
    rsp_at    = -1;
    strobe_at = -1;
    e_wr_addr = '0;
    e_rd_addr = '0;
    e_wr_data = '0;
  endfunction

  always @(negedge clk) begin
    logic [NUM_CH-1:0] e_ready, e_valid, e_err;
    int g, best, d;
    e_ready = '0; e_valid = '0; e_err = '0;
    if (!rst_n) begin
      model_reset();
      chk("mdl_reset_zero",
          {req_ready, rsp_valid, rsp_err, rsp_rdata, sd_wr_enable, sd_rd_enable}, '0);
      chk("mdl_reset_bus", {sd_wr_addr, sd_wr_data}, '0);
      chk("mdl_reset_rdaddr", sd_rd_addr, '0);
    end else begin
      // Winner is the valid channel closest after the last granted one.
      g = -1; best = NUM_CH;
      if (m_free && !sd_busy) begin
        for (int c = 0; c < NUM_CH; c++) begin
          d = (c - m_ptr - 1 + 2 * NUM_CH) % NUM_CH;
          if (req_valid[c] && d < best) begin best = d; g = c; end
        end
      end
      if (g >= 0) e_ready[g] = 1'b1;
      if (cyc == rsp_at) begin
        if (rsp_is_err) e_err[rsp_ch] = 1'b1;
        else            e_valid[rsp_ch] = 1'b1;
      end
      chk("mdl_req_ready", req_ready, e_ready);
      chk("mdl_wr_enable", sd_wr_enable, (cyc == strobe_at) && strobe_we);
      chk("mdl_rd_enable", sd_rd_enable, (cyc == strobe_at) && !strobe_we);
      chk("mdl_wr_addr", sd_wr_addr, e_wr_addr);
      chk("mdl_wr_data", sd_wr_data, e_wr_data);
      chk("mdl_rd_addr", sd_rd_addr, e_rd_addr);
      chk("mdl_rsp_valid", rsp_valid, e_valid);
      chk("mdl_rsp_err", rsp_err, e_err);
      if (e_valid != '0) chk("mdl_rsp_rdata", rsp_rdata, rsp_dat);

      if (g >= 0) begin
        m_ptr = g; m_free = 1'b0; cur_ch = g;
        strobe_at = cyc + 1; strobe_we = req_we[g];
        n_txn++;
        if (req_we[g]) begin
          e_wr_addr = req_addr[g*ADDR_W +: ADDR_W];
          e_wr_data = req_wdata[g*DATA_W +: DATA_W];
          wait_from = cyc + 3;
          $display("txn %0d cyc %0d: ch%0d write addr=%h data=%h", n_txn, cyc, g, e_wr_addr, e_wr_data);
        end else begin
          e_rd_addr = req_addr[g*ADDR_W +: ADDR_W];
          rd_open = 1'b1; rd_from = cyc + 3; rd_to = cyc + 2 + TIMEOUT_CYC;
          $display("txn %0d cyc %0d: ch%0d read  addr=%h", n_txn, cyc, g, e_rd_addr);
        end
      end
      if (rd_open && cyc >= rd_from) begin
        if (sd_rd_ready) begin
          rsp_at = cyc + 1; rsp_is_err = 1'b0; rsp_ch = cur_ch; rsp_dat = sd_rd_data;
          rd_open = 1'b0; wait_from = cyc + 1;
        end else if (cyc == rd_to) begin
          rsp_at = cyc + 1; rsp_is_err = 1'b1; rsp_ch = cur_ch;
          rd_open = 1'b0; wait_from = cyc + 1;
        end
      end
      if (wait_from >= 0 && cyc >= wait_from && !sd_busy) begin
        m_free = 1'b1; wait_from = -1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers (inputs change at posedge+1) ----------------
  task automatic nxt();
    logic [NUM_CH-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    req_valid   = req_valid & ~acc;
    sd_rd_ready = 1'b0;
  endtask

  task automatic set_req(int ch, bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] dt);
    req_valid[ch]                 = 1'b1;
    req_we[ch]                    = we;
    req_addr[ch*ADDR_W +: ADDR_W]  = a;
    req_wdata[ch*DATA_W +: DATA_W] = dt;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin @(negedge clk); nxt(); end
  endtask

  function automatic int oh_idx(logic [NUM_CH-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  int rr_q[$];
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin @(negedge clk); chk("rst_ready", req_ready, '0); nxt(); end
    rst_n = 1'b1;
    idle_cycles(2);

    // Single write on ch1
    set_req(1, 1'b1, 32'h100, 16'hBEEF);
    @(negedge clk); chk("wr_ready", req_ready, 4'b0010); nxt();
    @(negedge clk);
    chk("wr_en", sd_wr_enable, 1'b1);
    chk("wr_addr", sd_wr_addr, 32'h100);
    chk("wr_data", sd_wr_data, 16'hBEEF);
    chk("wr_ready_once", req_ready, '0);
    nxt(); sd_busy = 1'b1;
    @(negedge clk); chk("wr_en_1cyc", sd_wr_enable, 1'b0); nxt();
    idle_cycles(2);
    sd_busy = 1'b0;
    idle_cycles(3);

    // Read on ch2, data returned 5 cycles after the strobe
    set_req(2, 1'b0, 32'h20, 16'h0);
    @(negedge clk); chk("rd_ready", req_ready, 4'b0100); nxt();
    @(negedge clk); chk("rd_en", sd_rd_enable, 1'b1); chk("rd_addr", sd_rd_addr, 32'h20); nxt();
    idle_cycles(4);
    sd_rd_ready = 1'b1; sd_rd_data = 16'h1234;
    @(negedge clk); nxt();
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 4'b0100);
    chk("rd_rsp_rdata", rsp_rdata, 16'h1234);
    chk("rd_rsp_err", rsp_err, '0);
    nxt();
    @(negedge clk); chk("rd_rsp_pulse", rsp_valid, '0); nxt();
    idle_cycles(3);

    // Read timeout on ch3, then ch0 must win over ch1
    set_req(3, 1'b0, 32'h300, 16'h0);
    @(negedge clk); chk("to_ready", req_ready, 4'b1000); nxt();
    for (int k = 1; k <= 18; k++) begin
      if (k == 3) begin
        set_req(1, 1'b1, 32'h44, 16'h1111);
        set_req(0, 1'b1, 32'h40, 16'h5A5A);
      end
      @(negedge clk);
      if (k == 18) chk("to_err_early", rsp_err, '0);
      nxt();
    end
    @(negedge clk); chk("to_err", rsp_err, 4'b1000); chk("to_no_valid", rsp_valid, '0); nxt();
    @(negedge clk); chk("to_next_ch0", req_ready, 4'b0001); nxt();
    idle_cycles(12);

    // Reset while a ch1 read sits in WAIT_RD, then a late sd_rd_ready
    set_req(1, 1'b0, 32'h80, 16'h0);
    idle_cycles(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_ready", req_ready, '0);
    chk("mr_rd_addr", sd_rd_addr, '0);
    chk("mr_rsp", {rsp_valid, rsp_err}, '0);
    nxt();
    @(negedge clk); nxt();
    rst_n = 1'b1; sd_rd_ready = 1'b1; sd_rd_data = 16'hDEAD;
    repeat (4) begin @(negedge clk); chk("mr_no_rsp", rsp_valid, '0); nxt(); end

    // Round robin with all four channels requesting continuously
    for (int ch = 0; ch < NUM_CH; ch++) set_req(ch, 1'b1, 32'h1000 + ch, DATA_W'(ch));
    for (int k = 0; k < 200 && rr_q.size() < 5; k++) begin
      @(negedge clk);
      if (req_ready != '0) rr_q.push_back(oh_idx(req_ready));
      nxt();
      req_valid = '1;
    end
    req_valid = '0;
    chk("rr_grant_count", rr_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", (i < rr_q.size()) ? rr_q[i] : -1, rr_exp[i]);
    idle_cycles(10);

    // Busy backpressure for 20 cycles with ch0 waiting
    sd_busy = 1'b1;
    set_req(0, 1'b1, 32'h55, 16'h66);
    repeat (20) begin
      @(negedge clk);
      chk("bp_ready", req_ready, '0);
      chk("bp_strobe", {sd_wr_enable, sd_rd_enable}, '0);
      nxt();
    end
    sd_busy = 1'b0;
    @(negedge clk); chk("bp_accept", req_ready, 4'b0001); nxt();
    idle_cycles(10);

    // Randomized traffic
    for (int t = 0; t < 2000; t++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!req_valid[ch]) begin
          if ($urandom_range(2) == 0)
            set_req(ch, 1'($urandom_range(1)), ADDR_W'($urandom), DATA_W'($urandom));
        end else if ($urandom_range(39) == 0) begin
          req_valid[ch] = 1'b0;
        end
      end
      sd_busy     = ($urandom_range(3) == 0);
      sd_rd_ready = ($urandom_range(11) == 0);
      sd_rd_data  = DATA_W'($urandom);
      @(negedge clk);
      nxt();
    end
    req_valid = '0;
    sd_busy   = 1'b0;
    idle_cycles(TIMEOUT_CYC + 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
